// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional skid entry,
// synchronous flush and control fields forced to zero on bubbles.
module pipe_stage_reg #(
  parameter int CTRL_W = 10,
  parameter int DATA_W = 118,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, HOLD = 2'd1, FULL = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              accept, emit;

  assign out_valid = (state_q != EMPTY);

  // With a skid entry, in_ready depends on state only (no ready path through).
  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = (state_q != FULL);
    end else begin : g_noskid
      assign in_ready = !out_valid | out_ready;
    end
  endgenerate

  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;
  assign out_ctrl  = main_ctrl_q & {CTRL_W{out_valid}};
  assign out_data  = main_data_q;
  assign occupancy = {state_q == FULL, state_q == HOLD};
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    stall_cnt_d = stall_cnt_q;

    if (out_valid && !out_ready && stall_cnt_q != {CNT_W{1'b1}})
      stall_cnt_d = stall_cnt_q + CNT_W'(1);

    // Flush drops occupancy but keeps entry contents; out_ctrl is masked anyway.
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (accept) begin
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
          state_d     = HOLD;
        end
        HOLD: begin
          if (accept && emit) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (accept && SKID != 0) begin
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
            state_d     = FULL;
          end else if (emit) begin
            state_d = EMPTY;
          end
        end
        FULL: if (emit) begin
          main_ctrl_d = skid_ctrl_q;
          main_data_d = skid_data_q;
          state_d     = HOLD;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
